// File: rtl/seg_scan_ctrl.sv
// Scan controller for a 4-digit active-low 7-segment display, with tear-free buffered digit writes.
// Optional blinking of individual digits is enabled by defining SEG_BLINK_EN.
module seg_scan_ctrl #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int BLINK_ROUNDS = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [1:0] wr_digit,
    input  logic [6:0] wr_seg,
    input  logic       wr_dp,
    input  logic       wr_blink,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp,
    output logic [1:0] scan_idx
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;

    logic [CNT_W-1:0] cnt, cnt_next;
    logic [1:0]       idx_next;
    logic [0:0]       state, state_next;
    logic             wrap, commit, accept;

    logic             p_valid;
    logic [1:0]       p_digit;
    logic [6:0]       p_seg;
    logic             p_dp;

    logic [6:0]       seg_buf [4];
    logic [3:0]       dp_buf;

    logic             fwd, show, blink_hide;
    logic [6:0]       seg_sel;
    logic             dp_sel;

    assign wr_ready = !p_valid;

    always_comb begin
        wrap       = (cnt == CNT_LAST);
        cnt_next   = wrap ? '0 : cnt + CNT_W'(1);
        idx_next   = wrap ? scan_idx + 2'd1 : scan_idx;
        state_next = (cnt_next >= CNT_BLANK) ? ST_DRIVE : ST_BLANK;
        commit     = p_valid && !(state == ST_DRIVE && p_digit == scan_idx);
        accept     = wr_valid && !p_valid;
    end

    // A commit landing on the edge that selects the same digit is forwarded, so a slot never shows two values.
    always_comb begin
        fwd     = commit && (p_digit == idx_next);
        seg_sel = fwd ? p_seg : seg_buf[idx_next];
        dp_sel  = fwd ? p_dp : dp_buf[idx_next];
        show    = (state_next == ST_DRIVE) && !blink_hide;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            scan_idx <= 2'd0;
            state    <= ST_BLANK;
            p_valid  <= 1'b0;
            p_digit  <= 2'd0;
            p_seg    <= 7'b1111111;
            p_dp     <= 1'b1;
            for (int i = 0; i < 4; i++) begin
                seg_buf[i] <= 7'b1111111;
            end
            dp_buf   <= 4'b1111;
            an       <= 4'b1111;
            seg      <= 7'b1111111;
            dp       <= 1'b1;
        end else begin
            cnt      <= cnt_next;
            scan_idx <= idx_next;
            state    <= state_next;

            if (accept) begin
                p_valid <= 1'b1;
                p_digit <= wr_digit;
                p_seg   <= wr_seg;
                p_dp    <= wr_dp;
            end else if (commit) begin
                p_valid <= 1'b0;
            end

            if (commit) begin
                seg_buf[p_digit] <= p_seg;
                dp_buf[p_digit]  <= p_dp;
            end

            an  <= show ? ~(4'b0001 << idx_next) : 4'b1111;
            seg <= show ? seg_sel : 7'b1111111;
            dp  <= show ? dp_sel : 1'b1;
        end
    end

`ifdef SEG_BLINK_EN
    localparam int RND_W = (BLINK_ROUNDS > 1) ? $clog2(BLINK_ROUNDS) : 1;
    localparam logic [RND_W-1:0] RND_LAST = RND_W'(BLINK_ROUNDS - 1);

    logic [3:0]       blink_buf;
    logic             p_blink;
    logic [RND_W-1:0] rounds, rounds_next;
    logic             phase, phase_next, blink_sel;

    // The phase flips after BLINK_ROUNDS complete frames, counted at each 3->0 wrap.
    always_comb begin
        rounds_next = rounds;
        phase_next  = phase;
        if (wrap && scan_idx == 2'd3) begin
            if (rounds == RND_LAST) begin
                rounds_next = '0;
                phase_next  = !phase;
            end else begin
                rounds_next = rounds + RND_W'(1);
            end
        end
        blink_sel  = fwd ? p_blink : blink_buf[idx_next];
        blink_hide = phase_next && blink_sel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_buf <= 4'b0000;
            p_blink   <= 1'b0;
            rounds    <= '0;
            phase     <= 1'b0;
        end else begin
            rounds <= rounds_next;
            phase  <= phase_next;
            if (accept) begin
                p_blink <= wr_blink;
            end
            if (commit) begin
                blink_buf[p_digit] <= p_blink;
            end
        end
    end
`else
    logic unused_wr_blink;

    assign blink_hide      = 1'b0;
    assign unused_wr_blink = wr_blink;
`endif

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: directed and random writes compared every cycle
// against a slot-arithmetic model of the display (honours SEG_BLINK_EN when defined).
module tb_seg_scan_ctrl;

    localparam int RDIV   = 8;
    localparam int BLANK  = 2;
    localparam int ROUNDS = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_valid;
    logic       wr_ready;
    logic [1:0] wr_digit;
    logic [6:0] wr_seg;
    logic       wr_dp;
    logic       wr_blink;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    logic [1:0] scan_idx;

    int checks = 0;
    int passes = 0;

    // Model: k counts clock edges since reset; slot and phase follow from k by division.
    int         k;
    bit         m_pv;
    int         m_pd;
    logic [6:0] m_ps;
    logic       m_pdp;
    logic       m_pb;
    logic [6:0] m_seg [4];
    logic       m_dp  [4];
    logic       m_blk [4];
    bit         last_acc;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .REFRESH_DIV (RDIV),
        .BLANK_CYCLES(BLANK),
        .BLINK_ROUNDS(ROUNDS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_digit(wr_digit),
        .wr_seg  (wr_seg),
        .wr_dp   (wr_dp),
        .wr_blink(wr_blink),
        .seg     (seg),
        .an      (an),
        .dp      (dp),
        .scan_idx(scan_idx)
    );

    function automatic bit drives(int t);
        return (t % RDIV) >= BLANK;
    endfunction

    function automatic int slot(int t);
        return (t / RDIV) % 4;
    endfunction

    task automatic modelReset();
        k    = 0;
        m_pv = 0;
        m_pd = 0;
        for (int i = 0; i < 4; i++) begin
            m_seg[i] = 7'b1111111;
            m_dp[i]  = 1'b1;
            m_blk[i] = 1'b0;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("[TB] FAIL %s: observed %b expected %b (k=%0d)", tag, obs, exp, k);
    endtask

    task automatic clockCycle();
        bit         commit;
        bit         show;
        int         i;
        logic [3:0] e_an;
        if (rst) begin
            modelReset();
            last_acc = 0;
        end else begin
            commit   = m_pv && !(drives(k) && m_pd == slot(k));
            last_acc = wr_valid && !m_pv;
            if (commit) begin
                m_seg[m_pd] = m_ps;
                m_dp[m_pd]  = m_pdp;
                m_blk[m_pd] = m_pb;
                m_pv = 0;
            end
            if (last_acc) begin
                m_pv  = 1;
                m_pd  = int'(wr_digit);
                m_ps  = wr_seg;
                m_pdp = wr_dp;
                m_pb  = wr_blink;
            end
            k++;
        end
        @(posedge clk);
        #1;
        i    = slot(k);
        show = drives(k);
`ifdef SEG_BLINK_EN
        if (((k / (4 * RDIV)) / ROUNDS) % 2 == 1 && m_blk[i]) show = 0;
`endif
        e_an = show ? ~(4'b0001 << i) : 4'b1111;
        checkOutput("an", an, e_an);
        checkOutput("seg", seg, show ? m_seg[i] : 7'b1111111);
        checkOutput("dp", dp, show ? m_dp[i] : 1'b1);
        checkOutput("scan_idx", scan_idx, 7'(i));
        checkOutput("wr_ready", wr_ready, m_pv ? 7'd0 : 7'd1);
    endtask

    task automatic applyStimulus(input logic [1:0] d, input logic [6:0] s, input logic p, input logic b);
        wr_valid = 1'b1;
        wr_digit = d;
        wr_seg   = s;
        wr_dp    = p;
        wr_blink = b;
    endtask

    task automatic writeDigit(input logic [1:0] d, input logic [6:0] s, input logic p, input logic b);
        bit done = 0;
        applyStimulus(d, s, p, b);
        for (int n = 0; n < 64 && !done; n++) begin
            clockCycle();
            done = last_acc;
        end
        wr_valid = 1'b0;
        checkOutput("write_accepted", 7'(done), 7'd1);
    endtask

    task automatic waitSlot(input int d, input int c);
        bit found = 0;
        for (int n = 0; n < 200 && !found; n++) begin
            if (slot(k) == d && (k % RDIV) == c) found = 1;
            else clockCycle();
        end
        checkOutput("wait_slot", 7'(found), 7'd1);
    endtask

    task automatic runCycles(input int n);
        for (int j = 0; j < n; j++) clockCycle();
    endtask

    initial begin
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_digit = 2'd0;
        wr_seg   = 7'b1111111;
        wr_dp    = 1'b1;
        wr_blink = 1'b0;
        modelReset();
        last_acc = 0;

        runCycles(3);
        checkOutput("reset_an", an, 4'b1111);
        checkOutput("reset_ready", wr_ready, 1'b1);
        rst = 1'b0;
        runCycles(4 * RDIV + 4);

        // Non-conflicting write to digit 2 during digit 0 drive.
        waitSlot(0, 3);
        writeDigit(2'd2, 7'b1111110, 1'b0, 1'b0);
        runCycles(4 * RDIV);

        // Conflicting write: digit 1 written while it is being driven.
        waitSlot(1, 2);
        writeDigit(2'd1, 7'b0111111, 1'b1, 1'b0);
        checkOutput("conflict_pending", wr_ready, 1'b0);
        runCycles(4 * RDIV + RDIV);

        // Back-to-back writes with wr_valid held: conflicting digit 3, then digit 0.
        waitSlot(3, 3);
        writeDigit(2'd3, 7'b0000110, 1'b0, 1'b0);
        writeDigit(2'd0, 7'b0100100, 1'b1, 1'b0);
        runCycles(4 * RDIV + 4);

        // Randomized traffic holding each request stable until accepted.
        for (int n = 0; n < 400; n++) begin
            if (!wr_valid || last_acc) begin
                wr_valid = ($urandom_range(0, 2) == 0);
                wr_digit = 2'($urandom_range(0, 3));
                wr_seg   = 7'($urandom);
                wr_dp    = 1'($urandom);
                wr_blink = 1'($urandom);
            end
            clockCycle();
        end
        wr_valid = 1'b0;
        wr_blink = 1'b0;
        runCycles(2);

        // Reset mid-drive with a pending write; the write must vanish.
        waitSlot(2, 3);
        writeDigit(2'd2, 7'b0000000, 1'b0, 1'b0);
        checkOutput("mid_pending", wr_ready, 1'b0);
        rst = 1'b1;
        runCycles(1);
        checkOutput("mid_rst_ready", wr_ready, 1'b1);
        checkOutput("mid_rst_idx", scan_idx, 2'd0);
        checkOutput("mid_rst_seg", seg, 7'b1111111);
        rst = 1'b0;
        runCycles(4 * RDIV);

        // Blinking digit 0 over several blink phases.
        waitSlot(1, 4);
        writeDigit(2'd0, 7'b1000000, 1'b1, 1'b1);
        writeDigit(2'd3, 7'b1111001, 1'b1, 1'b0);
        runCycles(6 * 4 * RDIV);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
